snake_game_ctrl: RTL and testbench
==================================

// Module: snake_game_ctrl
// PURPOSE
//  Game sequencer for the snake playfield drawn by the background stage. Paces
//  snake movement off vsync, owns head/body/food cell positions, applies
//  direction input, detects wall/self collision and food capture, re-places food
//  from random_coordinates. Drives grid coordinates plus a registered per-cell
//  body_hit lookup that the draw pipeline queries with its hcount/vcount grid cell.
// PARAMETERS
//  FRAMES_PER_STEP  6   vsync rising edges between snake moves (>=1)
//  MAX_LEN          16  body segment storage depth (>=4)
//  INIT_LEN         3   length after reset/restart (<=MAX_LEN)
// PORTS
//  pclk       in   1  pixel clock, sole clock
//  rst_n      in   1  async active-low reset
//  vsync_in   in   1  vsync from timing chain; rising edge = frame tick
//  start      in   1  level; starts game (IDLE) / restarts (OVER)
//  btn_up/btn_down/btn_left/btn_right in 1 each  level, already synchronised
//  x_rand     in   7  random grid column (random_coordinates)
//  y_rand     in   6  random grid row
//  query_x    in   7  grid column to look up (hcount_in>>4)
//  query_y    in   6  grid row to look up (vcount_in>>4)
//  body_hit   out  1  registered: query cell holds a live body segment
//  head_x/head_y  out 7/6  current head cell
//  food_x/food_y  out 7/6  current food cell
//  snake_len  out  5  live segment count
//  score      out  8  foods eaten, saturates at 255
//  playing    out  1  1 in RUN/STEP/PLACE
//  game_over  out  1  1 in OVER
//  step_strobe out 1  1-cycle pulse when a move is committed
// BEHAVIOUR
//  Clock pclk; reset is asynchronous and active-low (rst_n); all state flops use it.
//  Grid 64x48 cells of 16 px. Walls: cols 12 and 51, rows 14 and 33; interior
//  cols 13..50, rows 15..32. Any cell outside interior is a wall hit.
//  Reset/restart values: state IDLE, head (32,24), body (32,24),(31,24),(30,24),
//  dir RIGHT, len INIT_LEN, food (40,24), score 0, tick cnt 0, all pulses 0, body_hit 0.
//  States: IDLE -start-> RUN; RUN -tick cnt==FRAMES_PER_STEP-1 on vsync edge-> STEP;
//  STEP -> OVER (collision) | PLACE (ate) | RUN; PLACE -valid cell-> RUN;
//  OVER -start-> reinit, IDLE (start must drop and rise again to run).
//  Tick: vsync_d register; edge = vsync_in & ~vsync_d; counter only advances in RUN,
//  wraps to 0 on the step edge.
//  Direction: sampled every cycle in RUN, priority up>down>left>right; stored in
//  pending_dir; a request opposite to committed dir is ignored; pending_dir becomes
//  dir at STEP. Multiple presses between steps: last legal one wins.
//  STEP (1 cycle): next = head +/-1. Collision if next is wall or equals segment
//  0..len-2 (tail vacates); on collision no body/head update, game_over next cycle.
//  Else shift body (seg[i]<=seg[i-1], seg[0]<=next), step_strobe=1. If next==food:
//  len<=min(len+1,MAX_LEN), score<=sat(score+1), seg[len] keeps old tail (growth).
//  PLACE: each cycle sample x_rand/y_rand; accept if interior and not on any live
//  segment -> food<=sample, RUN; else retry next cycle. No retry bound.
//  body_hit: 1-cycle latency, compare query cell with seg[0..len-1]; 0 in IDLE? no:
//  valid in all states, so initial snake is drawn before start.
//  Reset mid-game: immediate return to reset values regardless of state.
// STRUCTURE
//  snake_pkg: GRID constants (wall cols/rows, init head/food), state enum
//  (IDLE,RUN,STEP,PLACE,OVER), dir encoding (UP,DOWN,LEFT,RIGHT), opposite() fn.
//  Sub-module snake_body_store: MAX_LEN segment shift register, len-masked
//  compare ports (query hit, next-head self-hit, food-candidate hit).
// TESTING
//  Reset, start, 6 vsync edges, no keys -> one step_strobe, head (33,24), seg2 (31,24).
//  Keys none from (32,24) RIGHT -> after 18 steps head (50,24); 19th step -> game_over=1,
//   head stays (50,24), no step_strobe.
//  food at (40,24), run right -> on reaching it len 4, score 1, PLACE then new food
//   interior and off-body; force x_rand=12 for 5 cycles -> stays in PLACE.
//  dir RIGHT, press btn_left -> ignored; btn_up then btn_left before step -> UP taken?
//   no: last legal (LEFT illegal) so UP; head (32,23).
//  Self-collision: len 5, loop up/left/down -> game_over on hitting seg[1..3].
//  rst_n low during PLACE -> all outputs at reset values asynchronously; start resumes.

Source files
------------

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - grid constants, state/direction types and helpers for the snake game
package snake_pkg;

    localparam logic [6:0] WALL_LEFT   = 7'd12;
    localparam logic [6:0] WALL_RIGHT  = 7'd51;
    localparam logic [5:0] WALL_TOP    = 6'd14;
    localparam logic [5:0] WALL_BOT    = 6'd33;
    localparam logic [6:0] INIT_HEAD_X = 7'd32;
    localparam logic [5:0] INIT_HEAD_Y = 6'd24;
    localparam logic [6:0] INIT_FOOD_X = 7'd40;
    localparam logic [5:0] INIT_FOOD_Y = 6'd24;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_PLACE, S_OVER} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_UP:   return DIR_DOWN;
            DIR_DOWN: return DIR_UP;
            DIR_LEFT: return DIR_RIGHT;
            default:  return DIR_LEFT;
        endcase
    endfunction

    function automatic logic is_interior(input logic [6:0] x, input logic [5:0] y);
        return (x > WALL_LEFT) && (x < WALL_RIGHT) && (y > WALL_TOP) && (y < WALL_BOT);
    endfunction

endpackage

// File: rtl/snake_body_store.sv
// rtl/snake_body_store.sv - segment shift register with length-masked cell compares
module snake_body_store #(
    parameter int MAX_LEN = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_init,
    input  logic       i_shift,
    input  logic [6:0] i_next_x,
    input  logic [5:0] i_next_y,
    input  logic [4:0] i_len,
    input  logic [6:0] i_query_x,
    input  logic [5:0] i_query_y,
    input  logic [6:0] i_cand_x,
    input  logic [5:0] i_cand_y,
    output logic [6:0] o_head_x,
    output logic [5:0] o_head_y,
    output logic       o_query_hit,
    output logic       o_next_hit,
    output logic       o_cand_hit
);
    import snake_pkg::*;

    logic [6:0] r_seg_x [MAX_LEN];
    logic [5:0] r_seg_y [MAX_LEN];

    // Entries past the live length are don't-care; they just trail left of the head.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= INIT_HEAD_X - 7'(i);
                r_seg_y[i] <= INIT_HEAD_Y;
            end
        end else if (i_init) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= INIT_HEAD_X - 7'(i);
                r_seg_y[i] <= INIT_HEAD_Y;
            end
        end else if (i_shift) begin
            r_seg_x[0] <= i_next_x;
            r_seg_y[0] <= i_next_y;
            for (int i = 1; i < MAX_LEN; i++) begin
                r_seg_x[i] <= r_seg_x[i-1];
                r_seg_y[i] <= r_seg_y[i-1];
            end
        end
    end

    // The tail is excluded from the self-hit test because it vacates on the same move.
    always_comb begin
        o_query_hit = 1'b0;
        o_next_hit  = 1'b0;
        o_cand_hit  = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (5'(i) < i_len) begin
                if (r_seg_x[i] == i_query_x && r_seg_y[i] == i_query_y) o_query_hit = 1'b1;
                if (r_seg_x[i] == i_cand_x && r_seg_y[i] == i_cand_y)   o_cand_hit  = 1'b1;
            end
            if (5'(i) + 5'd1 < i_len) begin
                if (r_seg_x[i] == i_next_x && r_seg_y[i] == i_next_y)   o_next_hit  = 1'b1;
            end
        end
    end

    assign o_head_x = r_seg_x[0];
    assign o_head_y = r_seg_y[0];

endmodule

// File: rtl/snake_game_ctrl.sv
// rtl/snake_game_ctrl.sv - snake game sequencer: pacing, steering, collisions, food
module snake_game_ctrl #(
    parameter int FRAMES_PER_STEP = 6,
    parameter int MAX_LEN         = 16,
    parameter int INIT_LEN        = 3
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic       vsync_in,
    input  logic       start,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic [6:0] x_rand,
    input  logic [5:0] y_rand,
    input  logic [6:0] query_x,
    input  logic [5:0] query_y,
    output logic       body_hit,
    output logic [6:0] head_x,
    output logic [5:0] head_y,
    output logic [6:0] food_x,
    output logic [5:0] food_y,
    output logic [4:0] snake_len,
    output logic [7:0] score,
    output logic       playing,
    output logic       game_over,
    output logic       step_strobe
);
    import snake_pkg::*;

    localparam int             TW        = $clog2(FRAMES_PER_STEP + 1);
    localparam logic [TW-1:0]  TICK_LAST = TW'(FRAMES_PER_STEP - 1);
    localparam logic [4:0]     LEN_INIT  = 5'(INIT_LEN);
    localparam logic [4:0]     LEN_MAX   = 5'(MAX_LEN);

    state_t        r_state, w_state_nxt;
    dir_t          r_dir, r_pending_dir, w_req_dir;
    logic          w_req_valid;
    logic          r_vsync_d;
    logic [TW-1:0] r_tick_cnt;
    logic [4:0]    r_len;
    logic [6:0]    r_food_x;
    logic [5:0]    r_food_y;
    logic [7:0]    r_score;
    logic          r_step_strobe, r_body_hit, r_start_block;
    logic          w_tick, w_step_tick, w_collide, w_ate, w_shift, w_reinit, w_cand_ok;
    logic [6:0]    w_head_x, w_next_x;
    logic [5:0]    w_head_y, w_next_y;
    logic          w_query_hit, w_next_hit, w_cand_hit;

    snake_body_store #(.MAX_LEN(MAX_LEN)) u_body (
        .i_clk       (pclk),
        .i_rst_n     (rst_n),
        .i_init      (w_reinit),
        .i_shift     (w_shift),
        .i_next_x    (w_next_x),
        .i_next_y    (w_next_y),
        .i_len       (r_len),
        .i_query_x   (query_x),
        .i_query_y   (query_y),
        .i_cand_x    (x_rand),
        .i_cand_y    (y_rand),
        .o_head_x    (w_head_x),
        .o_head_y    (w_head_y),
        .o_query_hit (w_query_hit),
        .o_next_hit  (w_next_hit),
        .o_cand_hit  (w_cand_hit)
    );

    assign w_tick      = vsync_in & ~r_vsync_d;
    assign w_step_tick = w_tick && (r_tick_cnt == TICK_LAST);
    assign w_collide   = !is_interior(w_next_x, w_next_y) || w_next_hit;
    assign w_ate       = (w_next_x == r_food_x) && (w_next_y == r_food_y);
    assign w_cand_ok   = is_interior(x_rand, y_rand) && !w_cand_hit;

    // The move uses pending_dir, which becomes the committed dir on this same step.
    always_comb begin
        w_next_x = w_head_x;
        w_next_y = w_head_y;
        case (r_pending_dir)
            DIR_UP:   w_next_y = w_head_y - 6'd1;
            DIR_DOWN: w_next_y = w_head_y + 6'd1;
            DIR_LEFT: w_next_x = w_head_x - 7'd1;
            default:  w_next_x = w_head_x + 7'd1;
        endcase
    end

    always_comb begin
        w_req_valid = 1'b1;
        w_req_dir   = DIR_RIGHT;
        if (btn_up)         w_req_dir = DIR_UP;
        else if (btn_down)  w_req_dir = DIR_DOWN;
        else if (btn_left)  w_req_dir = DIR_LEFT;
        else if (btn_right) w_req_dir = DIR_RIGHT;
        else                w_req_valid = 1'b0;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift     = 1'b0;
        w_reinit    = 1'b0;
        case (r_state)
            S_IDLE:  if (start && !r_start_block) w_state_nxt = S_RUN;
            S_RUN:   if (w_step_tick) w_state_nxt = S_STEP;
            S_STEP: begin
                if (w_collide) begin
                    w_state_nxt = S_OVER;
                end else begin
                    w_shift     = 1'b1;
                    w_state_nxt = w_ate ? S_PLACE : S_RUN;
                end
            end
            S_PLACE: if (w_cand_ok) w_state_nxt = S_RUN;
            S_OVER: begin
                if (start) begin
                    w_reinit    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // A restart leaves start high; r_start_block holds IDLE until start is released.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_d     <= 1'b0;
            r_tick_cnt    <= '0;
            r_dir         <= DIR_RIGHT;
            r_pending_dir <= DIR_RIGHT;
            r_len         <= LEN_INIT;
            r_food_x      <= INIT_FOOD_X;
            r_food_y      <= INIT_FOOD_Y;
            r_score       <= 8'd0;
            r_step_strobe <= 1'b0;
            r_body_hit    <= 1'b0;
            r_start_block <= 1'b0;
        end else begin
            r_vsync_d     <= vsync_in;
            r_body_hit    <= w_query_hit;
            r_step_strobe <= w_shift;
            if (!start) r_start_block <= 1'b0;
            if (w_reinit) begin
                r_tick_cnt    <= '0;
                r_dir         <= DIR_RIGHT;
                r_pending_dir <= DIR_RIGHT;
                r_len         <= LEN_INIT;
                r_food_x      <= INIT_FOOD_X;
                r_food_y      <= INIT_FOOD_Y;
                r_score       <= 8'd0;
                r_start_block <= 1'b1;
            end else begin
                if (r_state == S_RUN) begin
                    if (w_tick) r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
                    if (w_req_valid && w_req_dir != opposite(r_dir)) r_pending_dir <= w_req_dir;
                end
                if (w_shift) begin
                    r_dir <= r_pending_dir;
                    if (w_ate) begin
                        if (r_len < LEN_MAX)   r_len   <= r_len + 5'd1;
                        if (r_score != 8'hFF)  r_score <= r_score + 8'd1;
                    end
                end
                if (r_state == S_PLACE && w_cand_ok) begin
                    r_food_x <= x_rand;
                    r_food_y <= y_rand;
                end
            end
        end
    end

    assign body_hit    = r_body_hit;
    assign head_x      = w_head_x;
    assign head_y      = w_head_y;
    assign food_x      = r_food_x;
    assign food_y      = r_food_y;
    assign snake_len   = r_len;
    assign score       = r_score;
    assign playing     = (r_state == S_RUN) || (r_state == S_STEP) || (r_state == S_PLACE);
    assign game_over   = (r_state == S_OVER);
    assign step_strobe = r_step_strobe;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb/tb_snake_game_ctrl.sv - randomized bench against a move-level snake model
`timescale 1ns/1ps
module tb_snake_game_ctrl;
    localparam int FPS  = 6;
    localparam int MAXL = 16;

    logic       pclk = 1'b0, rst_n = 1'b0, vsync_in = 1'b0, start = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [6:0] x_rand = 7'd0, query_x = 7'd0;
    logic [5:0] y_rand = 6'd0, query_y = 6'd0;
    logic       body_hit, playing, game_over, step_strobe;
    logic [6:0] head_x, food_x;
    logic [5:0] head_y, food_y;
    logic [4:0] snake_len;
    logic [7:0] score;

    snake_game_ctrl #(.FRAMES_PER_STEP(FPS), .MAX_LEN(MAXL), .INIT_LEN(3)) dut (
        .pclk(pclk), .rst_n(rst_n), .vsync_in(vsync_in), .start(start),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .x_rand(x_rand), .y_rand(y_rand), .query_x(query_x), .query_y(query_y),
        .body_hit(body_hit), .head_x(head_x), .head_y(head_y), .food_x(food_x), .food_y(food_y),
        .snake_len(snake_len), .score(score), .playing(playing), .game_over(game_over),
        .step_strobe(step_strobe)
    );

    always #5 pclk = ~pclk;

    int total = 0, bad = 0, strobes = 0;
    always @(negedge pclk) if (step_strobe) strobes++;

    // Model: body as queues (head first); dirs 0=up 1=down 2=left 3=right.
    int mx[$], my[$];
    int mdir, mpend, mfood_x, mfood_y, mscore, fix_x = 0, fix_y = 0;
    bit mover;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit on_body(input int x, input int y, input int n);
        for (int i = 0; i < n; i++) if (mx[i] == x && my[i] == y) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        mx.delete(); my.delete();
        for (int i = 0; i < 3; i++) begin mx.push_back(32 - i); my.push_back(24); end
        mdir = 3; mpend = 3; mfood_x = 40; mfood_y = 24; mscore = 0; mover = 1'b0;
    endtask

    task automatic check_state(input bit exp_play);
        chk("head_x", 32'(head_x), mx[0]);
        chk("head_y", 32'(head_y), my[0]);
        chk("food_x", 32'(food_x), mfood_x);
        chk("food_y", 32'(food_y), mfood_y);
        chk("snake_len", 32'(snake_len), mx.size());
        chk("score", 32'(score), mscore);
        chk("playing", 32'(playing), 32'(exp_play));
        chk("game_over", 32'(game_over), 32'(mover));
    endtask

    task automatic query_chk(input int x, input int y);
        @(negedge pclk); query_x = 7'(x); query_y = 6'(y);
        @(negedge pclk); chk("body_hit", 32'(body_hit), 32'(on_body(x, y, mx.size())));
    endtask

    task automatic press(input bit u, input bit d, input bit l, input bit r);
        int req;
        @(negedge pclk); btn_up = u; btn_down = d; btn_left = l; btn_right = r;
        @(negedge pclk); btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        req = u ? 0 : d ? 1 : l ? 2 : r ? 3 : -1;
        if (req >= 0 && req != (mdir ^ 1)) mpend = req;
    endtask

    task automatic run_start();
        @(negedge pclk); start = 1'b1;
        @(negedge pclk); start = 1'b0;
    endtask

    task automatic hard_reset();
        @(negedge pclk); rst_n = 1'b0;
        @(negedge pclk); rst_n = 1'b1;
        model_reset();
    endtask

    task automatic restart();
        @(negedge pclk); start = 1'b1;
        repeat (4) @(negedge pclk);
        chk("restart_hold_playing", 32'(playing), 0);
        chk("restart_game_over", 32'(game_over), 0);
        start = 1'b0;
        @(negedge pclk);
        model_reset();
        check_state(1'b0);
        run_start();
    endtask

    // mode 0: normal; 1: hold a wall sample in PLACE first; 2: leave the DUT parked in PLACE
    task automatic do_step(input int mode);
        int nx, ny, s0, cx, cy, ofx, ofy;
        bit ate, col;
        s0 = strobes; ofx = mfood_x; ofy = mfood_y;
        mdir = mpend;
        nx = mx[0]; ny = my[0];
        case (mdir)
            0: ny--;
            1: ny++;
            2: nx--;
            default: nx++;
        endcase
        col = nx < 13 || nx > 50 || ny < 15 || ny > 32 || on_body(nx, ny, mx.size() - 1);
        ate = !col && nx == mfood_x && ny == mfood_y;
        if (col) mover = 1'b1;
        else begin
            mx.push_front(nx); my.push_front(ny);
            if (!ate || mx.size() > MAXL) begin void'(mx.pop_back()); void'(my.pop_back()); end
            if (ate && mscore < 255) mscore++;
        end
        if (fix_x != 0) begin cx = fix_x; cy = fix_y; end
        else do begin
            cx = $urandom_range(50, 13); cy = $urandom_range(32, 15);
        end while (on_body(cx, cy, mx.size()));
        x_rand = (mode != 0) ? 7'd12 : 7'(cx);
        y_rand = 6'(cy);
        for (int f = 0; f < FPS; f++) begin
            vsync_in = 1'b1;
            repeat (3) @(negedge pclk);
            if (f == FPS - 1 && mode != 0) begin
                vsync_in = 1'b0;
                repeat (5) @(negedge pclk);
                chk("place_hold_food_x", 32'(food_x), ofx);
                chk("place_hold_food_y", 32'(food_y), ofy);
                chk("place_hold_playing", 32'(playing), 1);
                chk("place_len", 32'(snake_len), mx.size());
                if (mode == 2) return;
                x_rand = 7'(cx);
            end
            vsync_in = 1'b0;
            repeat (3) @(negedge pclk);
        end
        if (ate) begin mfood_x = cx; mfood_y = cy; end
        chk("step_strobe_count", strobes - s0, col ? 0 : 1);
        check_state(!mover);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int qx, qy, k, np;
        model_reset();
        repeat (3) @(negedge pclk);
        check_state(1'b0);
        chk("rst_step_strobe", 32'(step_strobe), 0);
        chk("rst_body_hit", 32'(body_hit), 0);
        rst_n = 1'b1;
        query_chk(31, 24); query_chk(30, 24); query_chk(33, 24);

        run_start();
        chk("start_playing", 32'(playing), 1);
        do_step(0);
        chk("first_head_x", 32'(head_x), 33);
        query_chk(31, 24); query_chk(30, 24);

        for (int s = 0; s < 10 && mx[0] < 39; s++) do_step(0);
        do_step(1);
        chk("eat_len", 32'(snake_len), 4);
        chk("eat_score", 32'(score), 1);
        for (int s = 0; s < 12 && mx[0] < 50; s++) do_step(0);
        chk("wall_reach_x", 32'(head_x), 50);
        do_step(0);
        chk("wall_game_over", 32'(game_over), 1);
        chk("wall_head_x", 32'(head_x), 50);

        restart();
        press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        do_step(0);
        chk("dir_up_head_x", 32'(head_x), 32);
        chk("dir_up_head_y", 32'(head_y), 23);
        do_step(0);

        hard_reset();
        run_start();
        fix_x = 41; fix_y = 24;
        for (int s = 0; s < 10 && mx[0] < 40; s++) do_step(0);
        fix_x = 20; fix_y = 20;
        do_step(0);
        fix_x = 0;
        chk("self_len", 32'(snake_len), 5);
        press(1, 0, 0, 0); do_step(0);
        press(0, 0, 1, 0); do_step(0);
        press(0, 1, 0, 0); do_step(0);
        chk("self_game_over", 32'(game_over), 1);

        for (int g = 0; g < 6; g++) begin
            if (mover) restart();
            else begin hard_reset(); run_start(); end
            for (int s = 0; s < 40 && !mover; s++) begin
                np = $urandom_range(2, 0);
                for (int p = 0; p < np; p++) begin
                    k = $urandom_range(15, 0);
                    press(k[3], k[2], k[1], k[0]);
                end
                do_step(0);
                if ($urandom_range(1, 0) == 1) begin
                    k = $urandom_range(mx.size() - 1, 0); qx = mx[k]; qy = my[k];
                end else begin
                    qx = $urandom_range(63, 0); qy = $urandom_range(47, 0);
                end
                query_chk(qx, qy);
            end
        end

        hard_reset();
        run_start();
        for (int s = 0; s < 10 && mx[0] < 39; s++) do_step(0);
        do_step(2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_state(1'b0);
        chk("async_rst_strobe", 32'(step_strobe), 0);
        chk("async_rst_body_hit", 32'(body_hit), 0);
        @(negedge pclk); rst_n = 1'b1;
        run_start();
        do_step(0);
        chk("resume_head_x", 32'(head_x), 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
